div_hilo_ctrl: RTL

Sequencing and writeback stage wrapped around the combinational restoring divider (unsigned Q/M in, quotient/remainder out).
- Registers the operands and presents unsigned magnitudes to the divider.
- Holds them stable for a programmable multicycle settle window.
- Applies signed-result correction and writes quotient to LO and remainder to HI.
- Sits between the ALU operand bus and the HI/LO register pair of the datapath.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_sign_fix.sv | 18 +
 rtl/div_hilo_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divide sequencer.
// Optional stats counter is enabled with DIV_HILO_STATS_EN.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, modulo 2^WIDTH.
// Used for operand magnitudes and for signed result correction.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] neg_val;

    assign neg_val = '0 - value;
    assign result  = negate ? neg_val : value;

endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequencer/writeback around a combinational restoring divider; writes HI/LO.
// Define DIV_HILO_STATS_EN to add the saturating div_count output.
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH         = DIV_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_m,
    input  logic [WIDTH-1:0] div_result,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
`ifdef DIV_HILO_STATS_EN
    output logic [15:0]      div_count,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q_q, div_q_d;
    logic [WIDTH-1:0] div_m_q, div_m_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dbz_sel_q, dbz_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] dvd_mag, dsr_mag, quo_fix, rem_fix;
    logic             dvd_neg, dsr_neg, dsr_zero;

    assign dvd_neg  = signed_op & dividend[WIDTH-1];
    assign dsr_neg  = signed_op & divisor[WIDTH-1];
    assign dsr_zero = (divisor == '0);

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_dvd (
        .value (dividend),
        .negate(dvd_neg),
        .result(dvd_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_dsr (
        .value (divisor),
        .negate(dsr_neg),
        .result(dsr_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value (div_result),
        .negate(neg_q_q),
        .result(quo_fix)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value (div_remainder),
        .negate(neg_r_q),
        .result(rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_q_d   = div_q_q;
        div_m_d   = div_m_q;
        dvd_d     = dvd_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        dbz_sel_d = dbz_sel_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = dividend;
                    dbz_sel_d = dsr_zero;
                    if (dsr_zero) begin
                        state_d = WRITE;
                    end else begin
                        div_q_d = dvd_mag;
                        div_m_d = dsr_mag;
                        neg_q_d = dvd_neg ^ dsr_neg;
                        neg_r_d = dvd_neg;
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dbz_sel_q) begin
                    lo_d  = {WIDTH{DBZ_QUOTIENT[0]}};
                    hi_d  = dvd_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d  = quo_fix;
                    hi_d  = rem_fix;
                    dbz_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WAIT);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q_q   <= '0;
            div_m_q   <= '0;
            dvd_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            dbz_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q_q   <= div_q_d;
            div_m_q   <= div_m_d;
            dvd_q     <= dvd_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            dbz_sel_q <= dbz_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

`ifdef DIV_HILO_STATS_EN
    logic [15:0] cnt_ops_q, cnt_ops_d;

    always_comb begin
        cnt_ops_d = cnt_ops_q;
        if (done_d && cnt_ops_q != 16'hFFFF) begin
            cnt_ops_d = cnt_ops_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt_ops_q <= '0;
        end else begin
            cnt_ops_q <= cnt_ops_d;
        end
    end

    assign div_count = cnt_ops_q;
`endif

    assign div_q = div_q_q;
    assign div_m = div_m_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign dbz   = dbz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
